// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the add/sub datapath.
//   FP32_QNAN      canonical quiet NaN
//   FP32_EXP_BIAS  single-precision exponent bias
//   FP32_EXP_MAX   all-ones exponent field (inf/NaN)
//   fp32_unpacked_t  {sign, signed biased exp[9:0], mant[27:0]} from the adder
//   fp32_flags_t     {nv, of, uf, nx} status flags
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam int          FP32_EXP_BIAS = 127;
  localparam int          FP32_EXP_MAX  = 255;

  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exp;
    logic        [27:0] mant;
  } fp32_unpacked_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp32_flags_t;

endpackage

// File: rtl/fp32_lzc.sv
// 27-bit leading-zero counter.
//   i_data  [26:0] value to scan from bit 26 downwards
//   o_lzc   [4:0]  number of leading zeros (27 when i_data is zero)
module fp32_lzc (
  input  logic [26:0] i_data,
  output logic [4:0]  o_lzc
);

  // Scan upwards so the highest set bit is the last one to write the count.
  always_comb begin
    o_lzc = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (i_data[i]) o_lzc = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp32_result_packer.sv
// FP32 add/sub result packer: normalize, round-to-nearest-even and encode an
// IEEE-754 single-precision word with status flags, in a two-stage valid/ready
// pipeline.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid / o_ready            input handshake
//   i_sign, i_exp[9:0], i_mant[27:0]  unnormalized result (carry, hidden,
//                                frac[22:0], G, R, S)
//   i_nan, i_overflow, i_zero    operand exception flags (nan > ovf > zero)
//   o_valid / i_ready            output handshake
//   o_result[31:0]               encoded word
//   o_nv, o_of, o_uf, o_nx       invalid, overflow, underflow, inexact
// Configuration macro: FP32_PACK_SUBNORM_EN -- when defined, subnormal results
// are produced by gradual underflow; otherwise tiny results flush to signed zero.
module fp32_result_packer
  import fp32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_sign,
  input  logic [9:0]  i_exp,
  input  logic [27:0] i_mant,
  input  logic        i_nan,
  input  logic        i_overflow,
  input  logic        i_zero,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_nv,
  output logic        o_of,
  output logic        o_uf,
  output logic        o_nx
);

  // Round the normalized mantissa (hidden at [26], G/R/S at [2:0]) and encode.
  function automatic logic [35:0] pack_round(input logic sign,
                                             input logic signed [10:0] exp,
                                             input logic [26:0] mant);
    logic              g, r, s, up, tiny;
    logic [24:0]       sum;
    logic signed [10:0] e;
    logic [22:0]       frac;
    fp32_flags_t       f;
    logic [31:0]       res;
    g    = mant[2];
    r    = mant[1];
    s    = mant[0];
    up   = g & (r | s | mant[3]);
    sum  = {1'b0, mant[26:3]} + {24'b0, up};
    tiny = (exp == 11'sd0);
    e    = exp;
    frac = sum[22:0];
    if (sum[24]) begin
      e    = exp + 11'sd1;
      frac = sum[23:1];
    end else if (tiny && sum[23]) begin
      // Subnormal rounded up into the hidden position: smallest normal.
      e = 11'sd1;
    end
    f    = '0;
    f.nx = g | r | s;
    f.uf = tiny & f.nx;
    if (int'(e) >= FP32_EXP_MAX) begin
      res  = {sign, 8'hFF, 23'h0};
      f.of = 1'b1;
      f.nx = 1'b1;
    end else begin
      res = {sign, e[7:0], frac};
    end
    return {res, f};
  endfunction

  fp32_unpacked_t     w_in_p0;
  logic [26:0]        w_m_c;
  logic signed [10:0] w_e_c;
  logic signed [10:0] w_em1;
  logic [4:0]         w_lzc;
  logic [4:0]         w_lsh;
  logic [26:0]        w_lshifted;
  logic               w_spec_p0;
  logic [31:0]        w_spec_res_p0;
  fp32_flags_t        w_spec_flg_p0;
  logic signed [10:0] w_exp_p0;
  logic [26:0]        w_mant_p0;
  logic               w_adv_p1;
  logic               w_adv_p2;

  logic               r_vld_p1;
  logic               r_spec_p1;
  logic [31:0]        r_spec_res_p1;
  fp32_flags_t        r_spec_flg_p1;
  logic               r_sign_p1;
  logic signed [10:0] r_exp_p1;
  logic [26:0]        r_mant_p1;
  logic [35:0]        w_pack_p1;

  logic               r_vld_p2;
  logic [31:0]        r_result_p2;
  fp32_flags_t        r_flags_p2;

  assign w_in_p0 = {i_sign, i_exp, i_mant};

  // Handshake: each stage moves when it is empty or the stage after it moves.
  assign w_adv_p2 = ~r_vld_p2 | i_ready;
  assign w_adv_p1 = ~r_vld_p1 | w_adv_p2;
  assign o_ready  = w_adv_p1;

  // ---- stage 0: carry fold, normalize, special cases ----
  always_comb begin
    if (w_in_p0.mant[27]) begin
      w_m_c = {w_in_p0.mant[27:2], w_in_p0.mant[1] | w_in_p0.mant[0]};
      w_e_c = {w_in_p0.exp[9], w_in_p0.exp} + 11'sd1;
    end else begin
      w_m_c = w_in_p0.mant[26:0];
      w_e_c = {w_in_p0.exp[9], w_in_p0.exp};
    end
  end

  fp32_lzc u_lzc (
    .i_data (w_m_c),
    .o_lzc  (w_lzc)
  );

  // Left shift stops at exponent 1; anything still unnormalized is subnormal.
  assign w_em1      = w_e_c - 11'sd1;
  assign w_lsh      = ($signed({6'b0, w_lzc}) < w_em1) ? w_lzc : w_em1[4:0];
  assign w_lshifted = w_m_c << w_lsh;

`ifdef FP32_PACK_SUBNORM_EN
  logic [4:0]  w_rsh;
  logic [53:0] w_wide;
  assign w_rsh  = (w_e_c <= -11'sd26) ? 5'd27 : 5'(11'sd1 - w_e_c);
  assign w_wide = {w_m_c, 27'b0} >> w_rsh;
`endif

  always_comb begin
    w_spec_p0     = 1'b0;
    w_spec_res_p0 = '0;
    w_spec_flg_p0 = '0;
    w_exp_p0      = w_e_c;
    w_mant_p0     = w_m_c;
    if (i_nan) begin
      w_spec_p0        = 1'b1;
      w_spec_res_p0    = FP32_QNAN;
      w_spec_flg_p0.nv = 1'b1;
    end else if (i_overflow) begin
      w_spec_p0     = 1'b1;
      w_spec_res_p0 = {i_sign, 8'hFF, 23'h0};
    end else if (i_zero) begin
      w_spec_p0     = 1'b1;
      w_spec_res_p0 = {i_sign, 31'h0};
    end else if (w_m_c == 27'h0) begin
      // Exact cancellation returns +0 regardless of sign.
      w_spec_p0     = 1'b1;
      w_spec_res_p0 = 32'h0;
    end else if (w_e_c >= 11'sd1) begin
      w_mant_p0 = w_lshifted;
      w_exp_p0  = w_lshifted[26] ? (w_e_c - $signed({6'b0, w_lsh})) : 11'sd0;
`ifndef FP32_PACK_SUBNORM_EN
      if (!w_lshifted[26]) begin
        w_spec_p0        = 1'b1;
        w_spec_res_p0    = {i_sign, 31'h0};
        w_spec_flg_p0.uf = 1'b1;
        w_spec_flg_p0.nx = 1'b1;
      end
`endif
    end else begin
`ifdef FP32_PACK_SUBNORM_EN
      w_mant_p0 = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};
      w_exp_p0  = 11'sd0;
`else
      w_spec_p0        = 1'b1;
      w_spec_res_p0    = {i_sign, 31'h0};
      w_spec_flg_p0.uf = 1'b1;
      w_spec_flg_p0.nx = 1'b1;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_vld_p1 <= 1'b0;
    else if (w_adv_p1) r_vld_p1 <= i_valid;
  end

  always_ff @(posedge i_clk) begin
    if (w_adv_p1 && i_valid) begin
      r_spec_p1     <= w_spec_p0;
      r_spec_res_p1 <= w_spec_res_p0;
      r_spec_flg_p1 <= w_spec_flg_p0;
      r_sign_p1     <= i_sign;
      r_exp_p1      <= w_exp_p0;
      r_mant_p1     <= w_mant_p0;
    end
  end

  // ---- stage 1: round and encode ----
  assign w_pack_p1 = pack_round(r_sign_p1, r_exp_p1, r_mant_p1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p2    <= 1'b0;
      r_result_p2 <= '0;
      r_flags_p2  <= '0;
    end else if (w_adv_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_result_p2 <= r_spec_p1 ? r_spec_res_p1 : w_pack_p1[35:4];
        r_flags_p2  <= r_spec_p1 ? r_spec_flg_p1 : fp32_flags_t'(w_pack_p1[3:0]);
      end
    end
  end

  // ---- stage 2: output ----
  assign o_valid  = r_vld_p2;
  assign o_result = r_result_p2;
  assign o_nv     = r_flags_p2.nv;
  assign o_of     = r_flags_p2.of;
  assign o_uf     = r_flags_p2.uf;
  assign o_nx     = r_flags_p2.nx;

endmodule

// File: tb/tb_fp32_result_packer.sv
module tb_fp32_result_packer;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [9:0]  i_exp;
  logic [27:0] i_mant;
  logic        i_nan;
  logic        i_overflow;
  logic        i_zero;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_nv;
  logic        o_of;
  logic        o_uf;
  logic        o_nx;

  int n_pass  = 0;
  int n_total = 0;

  fp32_result_packer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sign     (i_sign),
    .i_exp      (i_exp),
    .i_mant     (i_mant),
    .i_nan      (i_nan),
    .i_overflow (i_overflow),
    .i_zero     (i_zero),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_nv       (o_nv),
    .o_of       (o_of),
    .o_uf       (o_uf),
    .o_nx       (o_nx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] expv);
    chk(tag, {28'b0, o_nv, o_of, o_uf, o_nx}, {28'b0, expv});
  endtask

  task automatic set_beat(input logic s, input logic [9:0] e, input logic [27:0] m,
                          input logic [2:0] exc);
    i_sign     = s;
    i_exp      = e;
    i_mant     = m;
    i_nan      = exc[2];
    i_overflow = exc[1];
    i_zero     = exc[0];
  endtask

  // One beat through an unstalled pipe: accepted at the next edge, result
  // visible after the edge after that. Expected flags are {nv,of,uf,nx}.
  task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                         input logic [27:0] m, input logic [2:0] exc,
                         input logic [31:0] er, input logic [3:0] ef);
    set_beat(s, e, m, exc);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    set_beat(1'b0, 10'd0, 28'h0, 3'b000);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    chk({tag, "_result"}, o_result, er);
    chk_flags({tag, "_flags"}, ef);
  endtask

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    set_beat(1'b0, 10'd0, 28'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'h0);
    chk_flags("rst_flags", 4'b0000);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);

    run_one("identity", 1'b0, 10'd127, 28'h4000000, 3'b000, 32'h3F800000, 4'b0000);
    run_one("nan_ovf", 1'b0, 10'd127, 28'h4000000, 3'b110, 32'h7FC00000, 4'b1000);
    run_one("neg_inf", 1'b1, 10'd0, 28'h0, 3'b010, 32'hFF800000, 4'b0000);
    run_one("neg_zero", 1'b1, 10'd0, 28'h0, 3'b001, 32'h80000000, 4'b0000);
    run_one("rne_tie_even", 1'b0, 10'd127, 28'h4000004, 3'b000, 32'h3F800000, 4'b0001);
    run_one("rne_tie_up", 1'b0, 10'd127, 28'h400000C, 3'b000, 32'h3F800002, 4'b0001);
    run_one("carry_ovf", 1'b0, 10'd254, 28'h8000000, 3'b000, 32'h7F800000, 4'b0101);
    run_one("carry_2", 1'b0, 10'd127, 28'h8000000, 3'b000, 32'h40000000, 4'b0000);
    run_one("round_renorm", 1'b0, 10'd127, 28'h7FFFFFC, 3'b000, 32'h40000000, 4'b0001);
    run_one("cancel", 1'b0, 10'd127, 28'h0000008, 3'b000, 32'h34000000, 4'b0000);
    run_one("exact_zero", 1'b1, 10'd127, 28'h0000000, 3'b000, 32'h00000000, 4'b0000);
`ifdef FP32_PACK_SUBNORM_EN
    run_one("subn_exp0", 1'b0, 10'd0, 28'h4000000, 3'b000, 32'h00400000, 4'b0000);
    run_one("subn_lsh", 1'b0, 10'd1, 28'h2000000, 3'b000, 32'h00400000, 4'b0000);
    run_one("subn_inexact", 1'b0, 10'd0, 28'h4000004, 3'b000, 32'h00400000, 4'b0011);
`else
    run_one("ftz_exp0", 1'b0, 10'd0, 28'h4000000, 3'b000, 32'h00000000, 4'b0011);
    run_one("ftz_lsh", 1'b1, 10'd1, 28'h2000000, 3'b000, 32'h80000000, 4'b0011);
    run_one("ftz_inexact", 1'b0, 10'd0, 28'h4000004, 3'b000, 32'h00000000, 4'b0011);
`endif

    // Backpressure: three back-to-back beats with the sink stalled.
    @(posedge clk); #1;
    i_ready = 1'b0;
    set_beat(1'b0, 10'd127, 28'h4000000, 3'b000);
    i_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_a", {31'b0, o_ready}, 32'd1);
    set_beat(1'b0, 10'd128, 28'h4000000, 3'b000);
    @(posedge clk); #1;
    chk("bp_valid_a", {31'b0, o_valid}, 32'd1);
    chk("bp_result_a", o_result, 32'h3F800000);
    set_beat(1'b0, 10'd126, 28'h4000000, 3'b000);
    chk("bp_ready_full", {31'b0, o_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_hold_a1", o_result, 32'h3F800000);
    chk("bp_ready_full1", {31'b0, o_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_hold_a2", o_result, 32'h3F800000);
    chk("bp_hold_valid", {31'b0, o_valid}, 32'd1);
    i_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'b0, o_ready}, 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("bp_result_b", o_result, 32'h40000000);
    chk("bp_valid_b", {31'b0, o_valid}, 32'd1);
    @(posedge clk); #1;
    chk("bp_result_c", o_result, 32'h3F000000);
    chk("bp_valid_c", {31'b0, o_valid}, 32'd1);
    @(posedge clk); #1;
    chk("bp_drained", {31'b0, o_valid}, 32'd0);

    // Reset with beats in flight.
    i_ready = 1'b0;
    set_beat(1'b0, 10'd127, 28'h4000000, 3'b000);
    i_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("mid_valid_pre", {31'b0, o_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("mid_rst_result", o_result, 32'h0);
    chk("mid_rst_ready", {31'b0, o_ready}, 32'd1);
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_no_ghost", {31'b0, o_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp32_result_packer.md
# fp32_result_packer

- Output stage of the FP32 add/sub datapath; the encoding end of the operand exception classifier.
- Accepts an unpacked, unnormalized sum/difference plus the exception flags (NaN, overflow, zero) raised on the operands.
- Normalizes, rounds to nearest-even, and encodes the IEEE-754 single-precision word with accrued status flags.
- Two-stage valid/ready pipeline sitting between the mantissa adder and the writeback register.

## Interface
- No parameters.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  input beat valid.
- o_ready  out  1  packer can accept a beat this cycle.
- i_sign  in  1  result sign; for special cases, the sign chosen upstream.
- i_exp  in  10  signed biased exponent of i_mant[26].
- i_mant  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S.
- i_nan, i_overflow, i_zero  in  1 each  operand exception flags, mutually prioritized here.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  32  IEEE-754 word.
- o_nv, o_of, o_uf, o_nx  out  1 each  invalid, overflow, underflow, inexact.

## Operation
- Priority: i_nan > i_overflow > i_zero > computed.
  - i_nan gives 32'h7FC00000, o_nv=1.
  - i_overflow gives {i_sign, 8'hFF, 23'h0} with no flags (exact infinity).
  - i_zero gives {i_sign, 31'h0}.
- Stage 1, normalize:
  - i_mant[27]=1: shift right 1 with S |= dropped bit; exp+1.
  - Else mant[26:0]==0: exact result +0.
  - Else LZC on mant[26:0] (sub-module). Shift left by min(lzc, exp-1) when exp≥1.
  - Exp≤0: shift right by 1-exp, saturated at 27, all dropped bits OR'd into S; exp=0.
- Stage 2, round: RNE; round up when G & (R | S | mant[3]).
  - Carry into bit 27 renormalizes: exp+1.
  - Subnormal carry into bit 26 makes exp field 1.
  - o_nx = G|R|S.
- Overflow: final exp≥255 gives ±inf, o_of=1, o_nx=1.
- Underflow: o_uf=1 when the result is tiny (exp field 0 before rounding) and inexact.
- Flags are valid only with o_valid. The flags are per-result, not accumulated.

## Timing
- Latency: 2 cycles from an accepted input to o_valid, with i_ready held high. Throughput 1/cycle.
- Stage 2 advances when ~s2_valid | i_ready. Stage 1 advances when ~s1_valid | stage-2 advance.
- o_ready = ~s1_valid | stage-2 advance. This is combinational from i_ready.
- Output hold: o_valid, once asserted, holds with o_result and flags stable until i_ready.
- Simultaneous accept and drain in the same cycle loses no beat.
- Reset: o_valid=0, o_result=0, all flags 0, both stage valids 0. o_ready=1 the cycle after reset.
- Reset mid-stream discards in-flight beats. o_valid is 0 the next cycle.

## Configuration
- FP32_PACK_SUBNORM_EN defined: gradual underflow, subnormal results encoded as above.
- Undefined: flush-to-zero. Any result with exp field 0 and a nonzero mantissa becomes {sign, 31'h0} with o_uf=1, o_nx=1. The right-shift path is removed.

## Structure
- Shared package fp32_pkg holds:
  - constants FP32_QNAN=32'h7FC00000, FP32_EXP_BIAS=127, FP32_EXP_MAX=255;
  - typedef for the unpacked {sign, exp[9:0], mant[27:0]} record;
  - typedef for the 4-bit status flags.
- One sub-module: fp32_lzc, a 27-bit leading-zero counter with 5-bit output.

## Test plan
- Identity: i_exp=127, i_mant=28'h4000000, i_ready=1 → o_result=32'h3F800000 two cycles later, flags 0.
- Specials: i_nan=1 with i_overflow=1 → 32'h7FC00000, o_nv=1. i_overflow=1, i_sign=1 → 32'hFF800000, no flags.
- RNE:
  - i_exp=127, i_mant=28'h4000004 → 32'h3F800000, o_nx=1.
  - i_mant=28'h400000C → 32'h3F800002, o_nx=1.
- Carry and overflow: i_exp=254, i_mant=28'h8000000 → 32'h7F800000, o_of=1, o_nx=1.
- Cancellation: i_exp=127, i_mant=28'h0000008 → 32'h34000000, flags 0.
- Subnormal, i_exp=0, i_mant=28'h4000000:
  - with FP32_PACK_SUBNORM_EN → 32'h00400000, o_uf=0.
  - without it → 32'h00000000, o_uf=1, o_nx=1.
- Backpressure: 3 back-to-back beats with i_ready low for 3 cycles.
  - o_ready drops once both stages are full.
  - Results emerge in order with none lost.
  - Asserting i_rst mid-stream clears o_valid on the next cycle.
